// File: rtl/movegen_pos_loader.sv
// movegen_pos_loader: serialises a packed host board position into the movegen_square chain.
// Define MOVEGEN_LOADER_CLEAR_EN to add the CLR state that shifts an empty board on clear_req.
module movegen_pos_loader #(
    parameter int NSQ = 64,
    parameter int PW  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [7:0]    i_in_data,
    input  logic          i_in_last,
    input  logic          i_clear_req,
    output logic          o_pos_valid,
    output logic [PW-1:0] o_pos_data,
    output logic          o_stm,
    output logic [3:0]    o_castle,
    output logic          o_board_ready,
    output logic          o_load_err
);
    localparam int CW = $clog2(NSQ) + 1;

    typedef enum logic [2:0] {
        IDLE, LO, HI, WAIT, TRAIL, FLUSH
`ifdef MOVEGEN_LOADER_CLEAR_EN
        , CLR
`endif
    } state_t;

    state_t        r_state, w_next;
    logic          r_init, r_stm, r_ready, r_err;
    logic [7:0]    r_byte;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_castle;
    logic          w_xfer, w_clr, w_in_clr, w_start, w_full;
    logic          w_board, w_trail, w_clr_done;

`ifdef MOVEGEN_LOADER_CLEAR_EN
    assign w_clr    = r_init & i_clear_req;
    assign w_in_clr = r_state == CLR;
`else
    logic w_unused;
    assign w_unused = i_clear_req;
    assign w_clr    = 1'b0;
    assign w_in_clr = 1'b0;
`endif

    // HI keeps in_ready high so the next byte is registered while the high nibble shifts
    assign o_in_ready  = (r_state == IDLE) ? (r_init & ~w_clr)
                       : (r_state == HI) | (r_state == WAIT) | (r_state == TRAIL) | (r_state == FLUSH);
    assign w_xfer      = i_in_valid & o_in_ready;
    assign w_start     = (r_state == IDLE) & (w_xfer | w_clr);
    assign w_full      = (r_cnt + CW'(2)) == CW'(NSQ);
    assign o_pos_valid = (r_state == LO) | (r_state == HI) | w_in_clr;
    assign o_pos_data  = (r_state == LO) ? r_byte[PW-1:0]
                       : (r_state == HI) ? r_byte[2*PW-1:PW] : '0;
    assign o_stm         = r_stm;
    assign o_castle      = r_castle;
    assign o_board_ready = r_ready;
    assign o_load_err    = r_err;

    always_comb begin
        w_next     = r_state;
        w_board    = 1'b0;
        w_trail    = 1'b0;
        w_clr_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_board = w_xfer;
`ifdef MOVEGEN_LOADER_CLEAR_EN
                if (w_clr) w_next = CLR;
`endif
            end
            LO: w_next = HI;
            HI: begin
                w_board = w_xfer & ~w_full;
                w_trail = w_xfer & w_full;
                w_next  = w_full ? TRAIL : WAIT;
            end
            WAIT:  w_board = w_xfer;
            TRAIL: w_trail = w_xfer;
            FLUSH: w_next = (w_xfer & i_in_last) ? IDLE : FLUSH;
`ifdef MOVEGEN_LOADER_CLEAR_EN
            CLR: begin
                w_clr_done = r_cnt == CW'(NSQ - 1);
                w_next     = w_clr_done ? IDLE : CLR;
            end
`endif
            default: w_next = IDLE;
        endcase
        if (w_board) w_next = i_in_last ? FLUSH : LO;
        if (w_trail) w_next = i_in_last ? IDLE : FLUSH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_init   <= 1'b0;
            r_byte   <= '0;
            r_cnt    <= '0;
            r_stm    <= 1'b0;
            r_castle <= '0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_init  <= 1'b1;
            if (w_board & ~i_in_last) r_byte <= i_in_data;
            if (w_start) begin
                r_cnt   <= '0;
                r_ready <= 1'b0;
                r_err   <= 1'b0;
            end else if (r_state == HI) begin
                r_cnt <= r_cnt + CW'(2);
            end else if (w_in_clr) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // a framing error outranks the clear at load start
            if ((w_board & i_in_last) | (w_trail & ~i_in_last)) r_err <= 1'b1;
            if (w_trail & i_in_last) begin
                r_stm    <= i_in_data[0];
                r_castle <= i_in_data[4:1];
                r_ready  <= 1'b1;
            end
            if (w_clr_done) begin
                r_stm    <= 1'b0;
                r_castle <= '0;
                r_ready  <= 1'b1;
            end
        end
    end
endmodule
